data_merge: RTL and testbench

Two-to-one AXI-Stream merger that re-serialises a stream split into two paths in groups of `PP_GROUP*PACKET_SIZE` beats. It accepts exactly one group from input 1, then one group from input 2, and repeats, so beat order after the split is restored. It sits downstream of the per-path processing, at the point where the two paths rejoin. Output is registered: one-cycle latency, full throughput, no bubble at group boundaries.

---
 rtl/data_merge_pkg.sv | 11 +
 rtl/data_merge_if.sv | 29 ++
 rtl/data_merge_axis_out_reg.sv | 44 ++++
 rtl/data_merge.sv | 65 ++++++
 tb/tb_data_merge.sv | 131 +++++++++++++
 5 files changed

// File: rtl/data_merge_pkg.sv
// data_merge_pkg: path encodings and group-size derivation shared by the stream splitter and merger
package data_merge_pkg;
  localparam int CNT_W = 16;
  typedef enum logic {
    SEL_IN2 = 1'b0,
    SEL_IN1 = 1'b1
  } sel_e;
  function automatic int group_beats(input int pp_group, input int packet_size);
    return pp_group * packet_size;
  endfunction
endpackage

// File: rtl/data_merge_if.sv
// data_merge_if: two input streams and one merged output stream; axis_out_tlast only with DATA_MERGE_TLAST_EN
interface data_merge_if #(parameter int DW = 128);
  logic [DW-1:0] axis_in1_tdata;
  logic          axis_in1_tvalid;
  logic          axis_in1_tready;
  logic [DW-1:0] axis_in2_tdata;
  logic          axis_in2_tvalid;
  logic          axis_in2_tready;
  logic [DW-1:0] axis_out_tdata;
  logic          axis_out_tvalid;
  logic          axis_out_tready;
`ifdef DATA_MERGE_TLAST_EN
  logic          axis_out_tlast;
`endif
  modport slave (
    input  axis_in1_tdata, axis_in1_tvalid, axis_in2_tdata, axis_in2_tvalid, axis_out_tready,
`ifdef DATA_MERGE_TLAST_EN
    output axis_out_tlast,
`endif
    output axis_in1_tready, axis_in2_tready, axis_out_tdata, axis_out_tvalid
  );
  modport master (
    output axis_in1_tdata, axis_in1_tvalid, axis_in2_tdata, axis_in2_tvalid, axis_out_tready,
`ifdef DATA_MERGE_TLAST_EN
    input  axis_out_tlast,
`endif
    input  axis_in1_tready, axis_in2_tready, axis_out_tdata, axis_out_tvalid
  );
endinterface

// File: rtl/data_merge_axis_out_reg.sv
// data_merge_axis_out_reg: single-entry registered output stage; carries tlast only with DATA_MERGE_TLAST_EN
module data_merge_axis_out_reg #(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
`ifdef DATA_MERGE_TLAST_EN
  input  logic          i_last,
  output logic          o_last,
`endif
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_can_load
);
  logic          r_valid;
  logic [DW-1:0] r_data;
  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_can_load = !r_valid || i_ready;
  // load a new beat, otherwise drain once downstream takes the held one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
`ifdef DATA_MERGE_TLAST_EN
  logic r_last;
  assign o_last = r_last;
  // tlast travels with the data it marks
  always_ff @(posedge clk) begin
    if (reset) r_last <= 1'b0;
    else if (i_load) r_last <= i_last;
  end
`endif
endmodule

// File: rtl/data_merge.sv
// data_merge: strict group-alternating 2:1 stream merger with registered output; DATA_MERGE_TLAST_EN adds packet tlast
module data_merge
  import data_merge_pkg::*;
#(
  parameter int DW          = 128,
  parameter int PP_GROUP    = 2,
  parameter int PACKET_SIZE = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] counter_pm,
  data_merge_if.slave      bus
);
  localparam int               GROUP_BEATS = group_beats(PP_GROUP, PACKET_SIZE);
  localparam logic [CNT_W-1:0] GROUP_LAST  = CNT_W'(GROUP_BEATS - 1);
  sel_e             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sel_valid;
  logic             w_sel_ready;
  logic             w_acc;
  logic             w_can_load;
  logic [DW-1:0]    w_sel_data;
  assign counter_pm           = r_cnt;
  assign w_sel_valid          = (r_state == SEL_IN1) ? bus.axis_in1_tvalid : bus.axis_in2_tvalid;
  assign w_sel_data           = (r_state == SEL_IN1) ? bus.axis_in1_tdata : bus.axis_in2_tdata;
  assign w_sel_ready          = !reset && w_can_load;
  assign w_acc                = w_sel_valid && w_sel_ready;
  assign bus.axis_in1_tready  = w_sel_ready && (r_state == SEL_IN1);
  assign bus.axis_in2_tready  = w_sel_ready && (r_state == SEL_IN2);
  // count beats of the current group and hand over to the other path after the last one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEL_IN1;
      r_cnt   <= '0;
    end else if (w_acc) begin
      r_cnt   <= (r_cnt == GROUP_LAST) ? '0 : r_cnt + 1'b1;
      r_state <= (r_cnt != GROUP_LAST) ? r_state : (r_state == SEL_IN1) ? SEL_IN2 : SEL_IN1;
    end
  end
`ifdef DATA_MERGE_TLAST_EN
  localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PACKET_SIZE - 1);
  logic [CNT_W-1:0] r_pkt;
  logic             w_pkt_last;
  assign w_pkt_last = (r_pkt == PKT_LAST);
  // packet beat position, used to flag the last beat of each packet
  always_ff @(posedge clk) begin
    if (reset) r_pkt <= '0;
    else if (w_acc) r_pkt <= w_pkt_last ? '0 : r_pkt + 1'b1;
  end
`endif
  data_merge_axis_out_reg #(.DW(DW)) u_out (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_acc),
    .i_data     (w_sel_data),
`ifdef DATA_MERGE_TLAST_EN
    .i_last     (w_pkt_last),
    .o_last     (bus.axis_out_tlast),
`endif
    .i_ready    (bus.axis_out_tready),
    .o_valid    (bus.axis_out_tvalid),
    .o_data     (bus.axis_out_tdata),
    .o_can_load (w_can_load)
  );
endmodule

// File: tb/tb_data_merge.sv
// tb_data_merge: directed vector table plus a splitter-model round trip for data_merge
module tb_data_merge;
  typedef struct {
    logic       rst, v1;
    logic [7:0] d1;
    logic       v2;
    logic [7:0] d2;
    logic       ordy, e_r1, e_r2, e_ov;
    logic [7:0] e_od;
    logic [15:0] e_cnt;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] counter_pm;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        vecs[28];
  int          q1[$];
  int          q2[$];
  data_merge_if #(.DW(128)) bus();
  data_merge #(.DW(128), .PP_GROUP(2), .PACKET_SIZE(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .counter_pm (counter_pm),
    .bus        (bus)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic rst, v1, input logic [7:0] d1, input logic v2,
                              input logic [7:0] d2, input logic ordy, e_r1, e_r2, e_ov,
                              input logic [7:0] e_od, input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2; v.ordy = ordy;
    v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    int got;
    int cyc;
    bus.axis_in1_tvalid = 1'b0;
    bus.axis_in1_tdata  = '0;
    bus.axis_in2_tvalid = 1'b0;
    bus.axis_in2_tdata  = '0;
    bus.axis_out_tready = 1'b1;
    //              rst v1 d1     v2 d2     ordy r1 r2 ov od     cnt
    vecs[0]  = mk(1, 1, 8'h10, 1, 8'h20, 1, 0, 0, 0, 8'h00, 0);
    vecs[1]  = mk(0, 1, 8'h10, 1, 8'h20, 1, 1, 0, 0, 8'h00, 0);
    vecs[2]  = mk(0, 1, 8'h11, 1, 8'h20, 1, 1, 0, 1, 8'h10, 1);
    vecs[3]  = mk(0, 1, 8'h12, 1, 8'h20, 1, 1, 0, 1, 8'h11, 2);
    vecs[4]  = mk(0, 1, 8'h13, 1, 8'h20, 1, 1, 0, 1, 8'h12, 3);
    vecs[5]  = mk(0, 1, 8'h14, 1, 8'h20, 1, 0, 1, 1, 8'h13, 0);
    vecs[6]  = mk(0, 1, 8'h14, 1, 8'h21, 1, 0, 1, 1, 8'h20, 1);
    vecs[7]  = mk(0, 1, 8'h14, 1, 8'h22, 1, 0, 1, 1, 8'h21, 2);
    vecs[8]  = mk(0, 1, 8'h14, 1, 8'h23, 1, 0, 1, 1, 8'h22, 3);
    vecs[9]  = mk(0, 1, 8'h14, 1, 8'h24, 1, 1, 0, 1, 8'h23, 0);
    vecs[10] = mk(0, 1, 8'h15, 1, 8'h24, 1, 1, 0, 1, 8'h14, 1);
    vecs[11] = mk(0, 0, 8'h16, 1, 8'h24, 1, 1, 0, 1, 8'h15, 2);
    vecs[12] = mk(0, 0, 8'h16, 1, 8'h24, 1, 1, 0, 0, 8'h15, 2);
    vecs[13] = mk(0, 0, 8'h16, 1, 8'h24, 1, 1, 0, 0, 8'h15, 2);
    vecs[14] = mk(0, 1, 8'h16, 1, 8'h24, 1, 1, 0, 0, 8'h15, 2);
    for (int k = 15; k < 20; k++) vecs[k] = mk(0, 1, 8'h17, 1, 8'h24, 0, 0, 0, 1, 8'h16, 3);
    vecs[20] = mk(0, 1, 8'h17, 1, 8'h24, 1, 1, 0, 1, 8'h16, 3);
    vecs[21] = mk(0, 1, 8'h18, 1, 8'h24, 1, 0, 1, 1, 8'h17, 0);
    vecs[22] = mk(0, 1, 8'h18, 1, 8'h25, 1, 0, 1, 1, 8'h24, 1);
    vecs[23] = mk(0, 1, 8'h18, 1, 8'h26, 1, 0, 1, 1, 8'h25, 2);
    vecs[24] = mk(1, 1, 8'h18, 1, 8'h27, 1, 0, 0, 1, 8'h26, 3);
    vecs[25] = mk(0, 1, 8'h18, 1, 8'h27, 1, 1, 0, 0, 8'h00, 0);
    vecs[26] = mk(0, 0, 8'h19, 1, 8'h27, 1, 1, 0, 1, 8'h18, 1);
    vecs[27] = mk(0, 0, 8'h19, 1, 8'h27, 1, 1, 0, 0, 8'h18, 1);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      reset               = vecs[k].rst;
      bus.axis_in1_tvalid = vecs[k].v1;
      bus.axis_in1_tdata  = 128'(vecs[k].d1);
      bus.axis_in2_tvalid = vecs[k].v2;
      bus.axis_in2_tdata  = 128'(vecs[k].d2);
      bus.axis_out_tready = vecs[k].ordy;
      #1;
      n_vec++;
      chk($sformatf("v%0d in1_tready", k), 128'(bus.axis_in1_tready), 128'(vecs[k].e_r1));
      chk($sformatf("v%0d in2_tready", k), 128'(bus.axis_in2_tready), 128'(vecs[k].e_r2));
      chk($sformatf("v%0d out_tvalid", k), 128'(bus.axis_out_tvalid), 128'(vecs[k].e_ov));
      chk($sformatf("v%0d out_tdata", k), bus.axis_out_tdata, 128'(vecs[k].e_od));
      chk($sformatf("v%0d counter_pm", k), 128'(counter_pm), 128'(vecs[k].e_cnt));
    end
    @(negedge clk);
    reset = 1'b1;
    bus.axis_in1_tvalid = 1'b0;
    bus.axis_in2_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (((i / 4) % 2) == 0) q1.push_back(i);
      else q2.push_back(i);
    end
    got = 0;
    cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      bus.axis_in1_tvalid = (q1.size() > 0) && ($urandom_range(0, 3) != 0);
      if (q1.size() > 0) bus.axis_in1_tdata = 128'(q1[0]);
      bus.axis_in2_tvalid = (q2.size() > 0) && ($urandom_range(0, 3) != 0);
      if (q2.size() > 0) bus.axis_in2_tdata = 128'(q2[0]);
      bus.axis_out_tready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.axis_out_tvalid && bus.axis_out_tready) begin
        n_vec++;
        chk($sformatf("rt beat %0d", got), bus.axis_out_tdata, 128'(got));
`ifdef DATA_MERGE_TLAST_EN
        chk($sformatf("rt tlast %0d", got), 128'(bus.axis_out_tlast), 128'((got % 2) == 1));
`endif
        got++;
      end
      if (bus.axis_in1_tvalid && bus.axis_in1_tready) void'(q1.pop_front());
      if (bus.axis_in2_tvalid && bus.axis_in2_tready) void'(q2.pop_front());
    end
    if (got < 1000) begin
      n_err++;
      $display("FAIL rt timeout: got %0d beats expected 1000", got);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
